// File: rtl/core_pkg.sv
// Shared pipeline-control constants: forwarding selects, x0 index and the
// memory-wait FSM state encoding used by the hazard controller.
package core_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } hz_state_t;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding select for one source register; the younger
// MEM-stage result takes priority over the WB-stage result.
module fwd_unit
    import core_pkg::*;
(
    input  logic [4:0] rs_EX,
    input  logic [4:0] rd_MEM,
    input  logic       regwrite_MEM,
    input  logic [4:0] rd_WB,
    input  logic       regwrite_WB,
    output logic [1:0] sel
);

    // NOTE: assign a default before any branch so the comb block never infers a latch.
    always_comb begin
        sel = FWD_RF;
        if (regwrite_MEM && rd_MEM != REG_X0 && rd_MEM == rs_EX)
            sel = FWD_MEM;
        else if (regwrite_WB && rd_WB != REG_X0 && rd_WB == rs_EX)
            sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stall/flush/freeze controls, EX forwarding and the
// dmem-wait FSM with sticky timeout. Optional counters under HAZARD_PERF_EN.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs1_ID,
    input  logic [4:0] rs2_ID,
    input  logic       rs1_used_ID,
    input  logic       rs2_used_ID,
    input  logic [4:0] rs1_EX,
    input  logic [4:0] rs2_EX,
    input  logic [4:0] rd_EX,
    input  logic       memread_EX,
    input  logic       redirect_EX,
    input  logic [4:0] rd_MEM,
    input  logic       regwrite_MEM,
    input  logic       mem_req_MEM,
    input  logic       mem_ack,
    input  logic [4:0] rd_WB,
    input  logic       regwrite_WB,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_stall,
    output logic       idex_flush,
    output logic       freeze,
    output logic [1:0] fwdA,
    output logic [1:0] fwdB,
    output logic       mem_err
`ifdef HAZARD_PERF_EN
   ,output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_freeze_cnt
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    hz_state_t        state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, cnt_nxt;
    logic             hold, load_use;
    logic [1:0]       fwd_a_raw, fwd_b_raw;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = wait_cnt;
        case (state)
            RUN: if (mem_req_MEM && !mem_ack) begin
                state_nxt = MEM_WAIT;
                cnt_nxt   = CNT_W'(1);
            end
            MEM_WAIT: if (mem_ack) begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end else if (wait_cnt == TIMEOUT_LAST) begin
                state_nxt = MEM_ERR;
            end else begin
                cnt_nxt = wait_cnt + 1'b1;
            end
            MEM_ERR: state_nxt = MEM_ERR;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        case (state)
            RUN:      hold = mem_req_MEM && !mem_ack;
            MEM_WAIT: hold = !mem_ack;
            default:  hold = 1'b1;
        endcase
    end

    assign load_use = memread_EX && rd_EX != REG_X0 &&
                      ((rs1_used_ID && rs1_ID == rd_EX) || (rs2_used_ID && rs2_ID == rd_EX));

    // Redirect and load-use only act on cycles where the pipeline advances.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_stall = 1'b0;
        idex_flush = 1'b0;
        freeze     = 1'b0;
        if (reset) begin
            pc_en = 1'b1;
        end else if (hold) begin
            freeze  = 1'b1;
            pc_en   = 1'b0;
            ifid_en = 1'b0;
        end else if (redirect_EX) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_stall = 1'b1;
        end
    end

    assign mem_err = (state == MEM_ERR);

    fwd_unit u_fwd_a (
        .rs_EX        (rs1_EX),
        .rd_MEM       (rd_MEM),
        .regwrite_MEM (regwrite_MEM),
        .rd_WB        (rd_WB),
        .regwrite_WB  (regwrite_WB),
        .sel          (fwd_a_raw)
    );

    fwd_unit u_fwd_b (
        .rs_EX        (rs2_EX),
        .rd_MEM       (rd_MEM),
        .regwrite_MEM (regwrite_MEM),
        .rd_WB        (rd_WB),
        .regwrite_WB  (regwrite_WB),
        .sel          (fwd_b_raw)
    );

    assign fwdA = reset ? FWD_RF : fwd_a_raw;
    assign fwdB = reset ? FWD_RF : fwd_b_raw;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt  <= '0;
            perf_flush_cnt  <= '0;
            perf_freeze_cnt <= '0;
        end else begin
            if (idex_stall) perf_stall_cnt  <= perf_stall_cnt + 32'd1;
            if (idex_flush) perf_flush_cnt  <= perf_flush_cnt + 32'd1;
            if (freeze)     perf_freeze_cnt <= perf_freeze_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level reference model.
module tb_hazard_ctrl;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB;
    logic       rs1_used_ID, rs2_used_ID, memread_EX, redirect_EX;
    logic       regwrite_MEM, mem_req_MEM, mem_ack, regwrite_WB;
    logic       pc_en, ifid_en, ifid_flush, idex_stall, idex_flush, freeze, mem_err;
    logic [1:0] fwdA, fwdB;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: count of consecutive frozen cycles of the current access.
    int m_run = 0;
    bit m_err = 1'b0;

    logic       e_pc_en, e_ifid_en, e_ifid_flush, e_idex_stall, e_idex_flush, e_freeze, e_mem_err;
    logic [1:0] e_fwdA, e_fwdB;

    hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX), .memread_EX(memread_EX),
        .redirect_EX(redirect_EX), .rd_MEM(rd_MEM), .regwrite_MEM(regwrite_MEM),
        .mem_req_MEM(mem_req_MEM), .mem_ack(mem_ack), .rd_WB(rd_WB), .regwrite_WB(regwrite_WB),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_stall(idex_stall),
        .idex_flush(idex_flush), .freeze(freeze), .fwdA(fwdA), .fwdB(fwdB), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (regwrite_MEM && rd_MEM != 0 && rd_MEM == rs) return 2'b10;
        if (regwrite_WB && rd_WB != 0 && rd_WB == rs)    return 2'b01;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic compute_expected();
        logic lu, frz;
        lu = memread_EX && rd_EX != 0 &&
             ((rs1_used_ID && rs1_ID == rd_EX) || (rs2_used_ID && rs2_ID == rd_EX));
        frz = m_err || ((m_run > 0) ? !mem_ack : (mem_req_MEM && !mem_ack));
        e_pc_en = 1; e_ifid_en = 1; e_ifid_flush = 0; e_idex_stall = 0; e_idex_flush = 0;
        e_freeze = 0; e_fwdA = 2'b00; e_fwdB = 2'b00; e_mem_err = 0;
        if (!reset) begin
            e_fwdA    = fwd_ref(rs1_EX);
            e_fwdB    = fwd_ref(rs2_EX);
            e_mem_err = m_err;
            if (frz) begin
                e_freeze = 1; e_pc_en = 0; e_ifid_en = 0;
            end else if (redirect_EX) begin
                e_ifid_flush = 1; e_idex_flush = 1;
            end else if (lu) begin
                e_pc_en = 0; e_ifid_en = 0; e_idex_stall = 1;
            end
        end
    endtask

    // Inputs are already driven; check mid-cycle, then advance the model at the edge.
    task automatic cycle();
        #3;
        compute_expected();
        check("pc_en",      pc_en,      e_pc_en);
        check("ifid_en",    ifid_en,    e_ifid_en);
        check("ifid_flush", ifid_flush, e_ifid_flush);
        check("idex_stall", idex_stall, e_idex_stall);
        check("idex_flush", idex_flush, e_idex_flush);
        check("freeze",     freeze,     e_freeze);
        check("fwdA",       fwdA,       e_fwdA);
        check("fwdB",       fwdB,       e_fwdB);
        check("mem_err",    mem_err,    e_mem_err);
        @(posedge clk);
        if (reset) begin
            m_run = 0; m_err = 0;
        end else if (!m_err) begin
            if (e_freeze) begin
                m_run++;
                if (m_run == T) m_err = 1;
            end else begin
                m_run = 0;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        rs1_ID = 0; rs2_ID = 0; rs1_used_ID = 0; rs2_used_ID = 0;
        rs1_EX = 0; rs2_EX = 0; rd_EX = 0; memread_EX = 0; redirect_EX = 0;
        rd_MEM = 0; regwrite_MEM = 0; mem_req_MEM = 0; mem_ack = 0;
        rd_WB = 0; regwrite_WB = 0;
    endtask

    task automatic random_inputs();
        rs1_ID = 5'($urandom_range(0, 3));  rs2_ID = 5'($urandom_range(0, 3));
        rs1_EX = 5'($urandom_range(0, 3));  rs2_EX = 5'($urandom_range(0, 3));
        rd_EX  = 5'($urandom_range(0, 3));  rd_MEM = 5'($urandom_range(0, 3));
        rd_WB  = 5'($urandom_range(0, 3));
        rs1_used_ID  = 1'($urandom_range(0, 1)); rs2_used_ID = 1'($urandom_range(0, 1));
        memread_EX   = 1'($urandom_range(0, 1));
        redirect_EX  = ($urandom_range(0, 4) == 0);
        regwrite_MEM = 1'($urandom_range(0, 1)); regwrite_WB = 1'($urandom_range(0, 1));
        mem_req_MEM  = ($urandom_range(0, 3) == 0);
        mem_ack      = 1'($urandom_range(0, 1));
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(posedge clk); #1;

        // Reset with hazard-provoking inputs: outputs must sit at RUN-idle.
        random_inputs(); memread_EX = 1; rd_EX = 5; rs1_ID = 5; rs1_used_ID = 1;
        mem_req_MEM = 1; mem_ack = 0; regwrite_MEM = 1; rd_MEM = 3; rs1_EX = 3;
        cycle();
        reset = 1'b0; clear_inputs();
        cycle();

        // Load-use: one stall cycle, then the load forwards from MEM.
        memread_EX = 1; rd_EX = 5; rs1_ID = 5; rs1_used_ID = 1;
        cycle();
        check("lu_stall_const", {pc_en, ifid_en, idex_stall}, 3'b001);
        clear_inputs(); regwrite_MEM = 1; rd_MEM = 5; rs1_EX = 5;
        cycle();
        check("lu_fwdA_const", fwdA, 2'b10);

        // Load into x0 never stalls.
        clear_inputs(); memread_EX = 1; rd_EX = 0; rs1_ID = 0; rs1_used_ID = 1;
        cycle();

        // Redirect beats load-use.
        memread_EX = 1; rd_EX = 6; rs2_ID = 6; rs2_used_ID = 1; redirect_EX = 1;
        cycle();
        check("redir_lu_const", {ifid_flush, idex_flush, idex_stall, pc_en}, 4'b1101);

        // Three-cycle dmem wait with a redirect held pending, then ack.
        clear_inputs(); mem_req_MEM = 1; redirect_EX = 1;
        for (int i = 0; i < 3; i++) cycle();
        redirect_EX = 0; mem_ack = 1;
        cycle();
        check("ack_unfreeze_const", freeze, 1'b0);
        clear_inputs(); redirect_EX = 1;
        cycle();

        // Timeout: mem_err after the T-th frozen cycle, cleared by reset.
        clear_inputs(); mem_req_MEM = 1;
        for (int i = 0; i < T; i++) cycle();
        mem_ack = 1; redirect_EX = 1;
        cycle();
        check("timeout_err_const", mem_err, 1'b1);
        reset = 1'b1;
        cycle();
        reset = 1'b0; clear_inputs();
        cycle();
        check("err_cleared_const", mem_err, 1'b0);

        // Forwarding priority on operand B.
        regwrite_MEM = 1; rd_MEM = 7; regwrite_WB = 1; rd_WB = 7; rs2_EX = 7;
        cycle();
        regwrite_MEM = 0;
        cycle();
        rd_WB = 0;
        cycle();

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            random_inputs();
            reset = ($urandom_range(0, 49) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
